// File: rtl/pasta_pkg.sv
// Shared constants, S-box mode codes and controller state encoding for the PASTA round scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pasta_pkg;

   localparam int BITLEN  = 17;
   localparam int PASTA_S = 32;
   localparam int Q       = 65537;

   localparam logic [1:0] SB_NONE    = 2'd0;
   localparam logic [1:0] SB_FEISTEL = 2'd1;
   localparam logic [1:0] SB_CUBE    = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AFF_START,
      ST_AFF_WAIT,
      ST_MC_RST,
      ST_MC_RUN,
      ST_DONE,
      ST_ERR
   } ctrl_state_t;

   // Owner of the shared modular adder/multiplier arrays.
   typedef enum logic [1:0] {
      ARB_NONE,
      ARB_AFF,
      ARB_MC
   } arb_sel_t;

   // Feistel S-box on every pass except the last, which uses the cube S-box.
   function automatic logic [1:0] sb_mode_for(input logic [2:0] rnd, input int rounds);
      if (int'(rnd) < rounds - 1) begin
         return SB_FEISTEL;
      end else if (int'(rnd) == rounds - 1) begin
         return SB_CUBE;
      end
      return SB_NONE;
   endfunction

endpackage

// File: rtl/pasta_arith_mux.sv
// Two-source mux in front of the shared modular add/mul arrays; drives zero when no unit owns them.
// Latency: combinational.
// Backpressure: none; the selecting FSM decides ownership.
module pasta_arith_mux
   import pasta_pkg::*;
#(
   parameter int W = 544
) (
   input  arb_sel_t       sel,
   input  logic [W-1:0]   aff_modadd_in1,
   input  logic [W-1:0]   aff_modadd_in2,
   input  logic [W-1:0]   aff_modmul_in1,
   input  logic [W-1:0]   aff_modmul_in2,
   input  logic [W-1:0]   mc_modadd_in1,
   input  logic [W-1:0]   mc_modadd_in2,
   input  logic [W-1:0]   mc_modmul_in1,
   input  logic [W-1:0]   mc_modmul_in2,
   output logic [W-1:0]   modadd_in1,
   output logic [W-1:0]   modadd_in2,
   output logic [W-1:0]   modmul_in1,
   output logic [W-1:0]   modmul_in2
);

   // Route the owning unit's operands; idle arrays see zeros so they do not toggle.
   always_comb begin
      modadd_in1 = '0;
      modadd_in2 = '0;
      modmul_in1 = '0;
      modmul_in2 = '0;
      case (sel)
         ARB_AFF: begin
            modadd_in1 = aff_modadd_in1;
            modadd_in2 = aff_modadd_in2;
            modmul_in1 = aff_modmul_in1;
            modmul_in2 = aff_modmul_in2;
         end
         ARB_MC: begin
            modadd_in1 = mc_modadd_in1;
            modadd_in2 = mc_modadd_in2;
            modmul_in1 = mc_modmul_in1;
            modmul_in2 = mc_modmul_in2;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/pasta_round_ctrl.sv
// PASTA round scheduler: ROUNDS+1 affine layers interleaved with ROUNDS mix-column/S-box passes. Optional watchdog: PASTA_CTRL_WDOG_EN.
// Latency: 3 cycles per round plus 1 for DONE entry, on top of the affine and mix_column_sb latencies.
// Backpressure: ks_valid is held with a stable ks_out until ks_ready; start is ignored outside IDLE.
module pasta_round_ctrl #(
   parameter int ROUNDS  = 3,
   parameter int BITLEN  = pasta_pkg::BITLEN,
   parameter int PASTA_S = pasta_pkg::PASTA_S
`ifdef PASTA_CTRL_WDOG_EN
   ,
   parameter int WDOG_LIMIT = 255
`endif
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [BITLEN*PASTA_S-1:0]   in_l,
   input  logic [BITLEN*PASTA_S-1:0]   in_r,
   output logic                        busy,
   output logic [BITLEN*PASTA_S-1:0]   ks_out,
   output logic                        ks_valid,
   input  logic                        ks_ready,
   output logic                        err,
   output logic                        aff_start,
   output logic [2:0]                  aff_round,
   output logic [BITLEN*PASTA_S-1:0]   aff_in_l,
   output logic [BITLEN*PASTA_S-1:0]   aff_in_r,
   input  logic                        aff_done,
   input  logic [BITLEN*PASTA_S-1:0]   aff_out_l,
   input  logic [BITLEN*PASTA_S-1:0]   aff_out_r,
   output logic                        rst_mc_sb,
   output logic [1:0]                  sb_mode,
   output logic [BITLEN*PASTA_S-1:0]   in_mc_l,
   output logic [BITLEN*PASTA_S-1:0]   in_mc_r,
   input  logic                        done_mc_sb,
   input  logic [BITLEN*PASTA_S-1:0]   out_sb_l,
   input  logic [BITLEN*PASTA_S-1:0]   out_sb_r,
   input  logic [BITLEN*PASTA_S-1:0]   aff_modadd_in1,
   input  logic [BITLEN*PASTA_S-1:0]   aff_modadd_in2,
   input  logic [BITLEN*PASTA_S-1:0]   aff_modmul_in1,
   input  logic [BITLEN*PASTA_S-1:0]   aff_modmul_in2,
   input  logic [BITLEN*PASTA_S-1:0]   mc_modadd_in1,
   input  logic [BITLEN*PASTA_S-1:0]   mc_modadd_in2,
   input  logic [BITLEN*PASTA_S-1:0]   mc_modmul_in1,
   input  logic [BITLEN*PASTA_S-1:0]   mc_modmul_in2,
   output logic [BITLEN*PASTA_S-1:0]   modadd_in1,
   output logic [BITLEN*PASTA_S-1:0]   modadd_in2,
   output logic [BITLEN*PASTA_S-1:0]   modmul_in1,
   output logic [BITLEN*PASTA_S-1:0]   modmul_in2
);

   import pasta_pkg::*;

   localparam int         W        = BITLEN * PASTA_S;
   localparam logic [2:0] RND_LAST = 3'(ROUNDS);

   ctrl_state_t  state_q, state_d;
   logic [W-1:0] st_l_q, st_r_q;
   logic [2:0]   rnd_q;
   logic [1:0]   sb_mode_q;
   logic         ld_in, ld_aff, ld_mc;
   logic         wd_expired;
   arb_sel_t     arb_sel;

`ifdef PASTA_CTRL_WDOG_EN
   localparam int WD_W = $clog2(WDOG_LIMIT + 1);

   logic [WD_W-1:0] wd_cnt_q;
   logic            in_wait;

   assign in_wait    = (state_q == ST_AFF_WAIT) || (state_q == ST_MC_RUN);
   assign wd_expired = in_wait && (wd_cnt_q == WD_W'(WDOG_LIMIT - 1));

   // Cycles spent in the current wait state; every wait is entered from a non-wait state, so it starts at 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt_q <= '0;
      end else if (in_wait) begin
         wd_cnt_q <= wd_cnt_q + WD_W'(1);
      end else begin
         wd_cnt_q <= '0;
      end
   end

   assign err = (state_q == ST_ERR);
`else
   assign wd_expired = 1'b0;
   assign err        = 1'b0;
`endif

   // Next-state and control decode; a completion pulse in the same cycle as the timeout wins.
   always_comb begin
      state_d   = state_q;
      ld_in     = 1'b0;
      ld_aff    = 1'b0;
      ld_mc     = 1'b0;
      busy      = 1'b0;
      aff_start = 1'b0;
      ks_valid  = 1'b0;
      rst_mc_sb = 1'b1;
      arb_sel   = ARB_NONE;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               ld_in   = 1'b1;
               state_d = ST_AFF_START;
            end
         end
         ST_AFF_START: begin
            busy      = 1'b1;
            aff_start = 1'b1;
            arb_sel   = ARB_AFF;
            state_d   = ST_AFF_WAIT;
         end
         ST_AFF_WAIT: begin
            busy    = 1'b1;
            arb_sel = ARB_AFF;
            if (aff_done) begin
               ld_aff  = 1'b1;
               state_d = (rnd_q == RND_LAST) ? ST_DONE : ST_MC_RST;
            end else if (wd_expired) begin
               state_d = ST_ERR;
            end
         end
         ST_MC_RST: begin
            busy    = 1'b1;
            arb_sel = ARB_MC;
            state_d = ST_MC_RUN;
         end
         ST_MC_RUN: begin
            busy      = 1'b1;
            rst_mc_sb = 1'b0;
            arb_sel   = ARB_MC;
            if (done_mc_sb) begin
               ld_mc   = 1'b1;
               state_d = ST_AFF_START;
            end else if (wd_expired) begin
               state_d = ST_ERR;
            end
         end
         ST_DONE: begin
            ks_valid = 1'b1;
            if (ks_ready) begin
               state_d = ST_IDLE;
            end
         end
         ST_ERR: begin
            state_d = ST_ERR;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, permutation state and round counter; sb_mode is latched on MC_RST entry and cleared on leaving MC_RUN.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         st_l_q    <= '0;
         st_r_q    <= '0;
         rnd_q     <= '0;
         sb_mode_q <= SB_NONE;
      end else begin
         state_q <= state_d;
         if (ld_in) begin
            st_l_q <= in_l;
            st_r_q <= in_r;
            rnd_q  <= '0;
         end else if (ld_aff) begin
            st_l_q <= aff_out_l;
            st_r_q <= aff_out_r;
         end else if (ld_mc) begin
            st_l_q <= out_sb_l;
            st_r_q <= out_sb_r;
            rnd_q  <= rnd_q + 3'd1;
         end
         if (state_d == ST_MC_RST) begin
            sb_mode_q <= sb_mode_for(rnd_q, ROUNDS);
         end else if (state_d != ST_MC_RUN) begin
            sb_mode_q <= SB_NONE;
         end
      end
   end

   assign aff_round = rnd_q;
   assign sb_mode   = sb_mode_q;
   assign aff_in_l  = st_l_q;
   assign aff_in_r  = st_r_q;
   assign in_mc_l   = st_l_q;
   assign in_mc_r   = st_r_q;
   assign ks_out    = st_l_q;

   pasta_arith_mux #(
      .W (W)
   ) u_arith_mux (
      .sel            (arb_sel),
      .aff_modadd_in1 (aff_modadd_in1),
      .aff_modadd_in2 (aff_modadd_in2),
      .aff_modmul_in1 (aff_modmul_in1),
      .aff_modmul_in2 (aff_modmul_in2),
      .mc_modadd_in1  (mc_modadd_in1),
      .mc_modadd_in2  (mc_modadd_in2),
      .mc_modmul_in1  (mc_modmul_in1),
      .mc_modmul_in2  (mc_modmul_in2),
      .modadd_in1     (modadd_in1),
      .modadd_in2     (modadd_in2),
      .modmul_in1     (modmul_in1),
      .modmul_in2     (modmul_in2)
   );

endmodule

// File: doc/pasta_round_ctrl.md
# pasta_round_ctrl

- Round scheduler for the PASTA keystream permutation.
- Holds the 2×544-bit permutation state and runs R+1 affine layers through the external affine unit.
- Runs the R mix-column/S-box passes through `mix_column_sb`, selecting `sb_mode` for each pass.
- Arbitrates the shared modular adder/multiplier arrays between the affine unit and `mix_column_sb`.
- Sits between the top-level keystream interface and both datapath units.

## Interface
- Parameters:
  - ROUNDS, 3: S-box rounds R. 3 selects PASTA-3, 4 selects PASTA-4.
  - BITLEN, 17: bits per field word.
  - PASTA_S, 32: words per half-state. Bus width W = BITLEN*PASTA_S = 544.
  - WDOG_LIMIT, 255: watchdog timeout in cycles (only with the macro).
- Clock and reset:
  - clk, in, 1: clock.
  - rst, in, 1: synchronous, active-high reset.
- Top-level handshake:
  - start, in, 1: begin a permutation. Sampled only in IDLE.
  - in_l / in_r, in, W each: initial state, sampled with start.
  - busy, out, 1: high from the start-accept edge until DONE or ERR.
  - ks_out, out, W: keystream. Left half of the final state.
  - ks_valid, out, 1: level signal, held until ks_ready.
  - ks_ready, in, 1: keystream consumer ready.
  - err, out, 1: sticky watchdog error.
- Affine unit:
  - aff_start, out, 1: one-cycle pulse.
  - aff_round, out, 3: round index.
  - aff_in_l / aff_in_r, out, W: state registers.
  - aff_done, in, 1: one-cycle pulse. aff_out is valid in the same cycle.
  - aff_out_l / aff_out_r, in, W: affine result.
- mix_column_sb:
  - rst_mc_sb, out, 1: block reset/park.
  - sb_mode, out, 2: S-box mode.
  - in_mc_l / in_mc_r, out, W: state registers.
  - done_mc_sb, in, 1: level signal.
  - out_sb_l / out_sb_r, in, W: result.
- Arithmetic arbitration:
  - aff_modadd_in1/2, aff_modmul_in1/2, in, W each: affine unit requests.
  - mc_modadd_in1/2, mc_modmul_in1/2, in, W each: mix_column_sb requests.
  - modadd_in1/2, modmul_in1/2, out, W each: to the shared arrays.
  - Array outputs fan out directly to both units; they do not pass through this block.

## Operation
- States: IDLE, AFF_START, AFF_WAIT, MC_RST, MC_RUN, DONE, ERR.
- IDLE:
  - On start: st_l ← in_l, st_r ← in_r, rnd ← 0.
  - Next state AFF_START.
- AFF_START:
  - aff_start = 1.
  - Next state AFF_WAIT.
- AFF_WAIT:
  - On aff_done: st ← aff_out.
  - If rnd == ROUNDS, next state DONE; otherwise MC_RST.
- MC_RST:
  - One cycle. Gives mix_column_sb a full reset cycle with st already stable.
  - Next state MC_RUN.
- MC_RUN:
  - rst_mc_sb = 0.
  - On done_mc_sb: st ← out_sb, rnd ← rnd+1.
  - Next state AFF_START.
- DONE:
  - ks_valid = 1, ks_out = st_l.
  - On ks_ready, next state IDLE.
- rst_mc_sb is 1 in every state except MC_RUN, which keeps the sub-block parked.
- in_mc and aff_in are driven continuously from st.
- sb_mode:
  - rnd < ROUNDS-1: 1 (Feistel).
  - rnd == ROUNDS-1: 2 (cube).
  - Otherwise: 0.
  - Value is registered and stable for the whole MC_RST/MC_RUN span.
- Arbitration (combinational from the registered state):
  - AFF_START and AFF_WAIT: affine buses selected.
  - MC_RST and MC_RUN: mc buses selected.
  - All other states: all four outputs driven to 0.
- Affine runs = ROUNDS+1. mix_column_sb runs = ROUNDS.
- Boundary conditions:
  - start outside IDLE is ignored.
  - start and ks_ready together in DONE: the handshake completes and start is ignored.
  - aff_done outside AFF_WAIT is ignored.
  - done_mc_sb outside MC_RUN is ignored.
  - rst at any cycle, including mid-round: next cycle is IDLE with every output at its reset value.

## Timing
- Reset values:
  - state = IDLE, rnd = 0, st = 0.
  - busy = 0, ks_valid = 0, aff_start = 0, err = 0.
  - rst_mc_sb = 1, sb_mode = 0.
  - All modadd/modmul outputs = 0.
- Start acceptance: start accepted at edge t. aff_start is high during cycle t+1.
- Affine capture: aff_done in cycle a → MC_RST in cycle a+1, rst_mc_sb falls in cycle a+2.
- mix_column_sb loads in_mc in its first cycle after rst_mc_sb falls. This equals st captured at edge a.
- MC capture: first cycle of done_mc_sb high → capture at that edge. rst_mc_sb is high again in the next cycle.
- Controller overhead: 3 cycles per round plus 1 for DONE entry, on top of the sub-unit latencies.
- Keystream release: ks_ready high in cycle d → ks_valid = 0 and IDLE in cycle d+1.

## Configuration
- Macro PASTA_CTRL_WDOG_EN.
- Defined:
  - A cycle counter (width clog2(WDOG_LIMIT+1)) clears on entering AFF_WAIT or MC_RUN and counts while in them.
  - Reaching WDOG_LIMIT moves the FSM to ERR: err = 1, busy = 0, rst_mc_sb = 1, arrays driven 0.
  - ERR is left only on rst.
- Undefined: no counter, err tied 0, and waits are unbounded.

## Structure
- Shared package pasta_pkg holds:
  - Constants BITLEN = 17, PASTA_S = 32, Q = 65537.
  - SB_NONE/SB_FEISTEL/SB_CUBE = 0/1/2.
  - The controller state enum.
- Sub-module pasta_arith_mux: the 4×W two-source mux with zero default. It is the only datapath in the block besides the st registers.

## Test plan
- **Reset:** pulse rst during active traffic. Next cycle:
  - busy = 0, ks_valid = 0, rst_mc_sb = 1, sb_mode = 0.
  - modadd_in1 = 0.
- **Nominal, ROUNDS = 3:**
  - Stubs: affine done 3 cycles after start with out = in+1 per word mod 65537; mc_sb done 10 cycles after rst falls with out = in.
  - Input: all words 65535.
  - Required: 4 aff_start pulses, aff_round 0,1,2,3, sb_mode sequence 1,1,2, ks_out words = 2.
- **ROUNDS = 4:** sb_mode sequence 1,1,1,2 and 5 affine pulses.
- **Backpressure:**
  - Hold ks_ready low 20 cycles and pulse start: ks_out stable, ks_valid stays 1, start ignored.
  - Release ks_ready: IDLE next cycle.
- **Arbitration:**
  - AFF_WAIT: modadd_in1 == aff_modadd_in1.
  - MC_RUN: modmul_in2 == mc_modmul_in2.
  - IDLE and DONE: all four buses 0.
- **Mid-run reset and watchdog:**
  - rst in round 2 MC_RUN → IDLE, rnd = 0. A fresh start then completes all rounds.
  - Macro on, WDOG_LIMIT = 255, affine stub never done: err = 1 exactly 255 cycles after AFF_WAIT entry.
  - Macro off, same stub: stuck in AFF_WAIT with err = 0.
